// File: rtl/spi_xfer_sequencer_if.sv
// Host-side push/pop interface of spi_xfer_sequencer: TX FIFO write port,
// RX FIFO first-word-fall-through read port and occupancy flags.
interface spi_xfer_sequencer_if #(
  parameter int unsigned DEPTH = 8
) ();
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          tx_wr_en;
  logic [7:0]    tx_wr_data;
  logic          rx_rd_en;
  logic [7:0]    rx_rd_data;
  logic          tx_full;
  logic          rx_empty;
  logic [CW-1:0] tx_count;
  logic [CW-1:0] rx_count;

  modport slave (
    input  tx_wr_en, tx_wr_data, rx_rd_en,
    output rx_rd_data, tx_full, rx_empty, tx_count, rx_count
  );

  modport master (
    output tx_wr_en, tx_wr_data, rx_rd_en,
    input  rx_rd_data, tx_full, rx_empty, tx_count, rx_count
  );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// Byte sequencer in front of SPI_master: TX FIFO -> one SPI transfer per byte -> RX FIFO.
// Optional WAIT watchdog enabled by defining SPI_SEQ_TIMEOUT_EN (widens err_sticky to 3 bits).
module spi_xfer_sequencer #(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned START_CYCLES   = 2,
  parameter int unsigned GAP_CYCLES     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    SPI_reset,
  input  logic                    seq_enable,
  input  logic                    cfg_msb,
  input  logic [1:0]              cfg_div,
  spi_xfer_sequencer_if.slave     host,
  output logic                    busy,
`ifdef SPI_SEQ_TIMEOUT_EN
  output logic [2:0]              err_sticky,
`else
  output logic [1:0]              err_sticky,
`endif
  input  logic                    err_clear,
  output logic [7:0]              SPI_data_trans,
  output logic                    SPI_MSB,
  output logic [1:0]              SPI_div,
  output logic                    SPI_start,
  input  logic                    SPI_flag,
  input  logic [7:0]              SPI_data_rec
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int unsigned EW   = 3;
  localparam int unsigned MAXA = (START_CYCLES > GAP_CYCLES) ? START_CYCLES : GAP_CYCLES;
  localparam int unsigned MAXC = (MAXA > TIMEOUT_CYCLES) ? MAXA : TIMEOUT_CYCLES;
`else
  localparam int unsigned EW   = 2;
  localparam int unsigned MAXC = (START_CYCLES > GAP_CYCLES) ? START_CYCLES : GAP_CYCLES;
`endif
  localparam int unsigned CNT_W = ($clog2(MAXC) > 0) ? $clog2(MAXC) : 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || START_CYCLES < 1 ||
      GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("spi_xfer_sequencer: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             start_nxt, launch, rx_push;
`ifdef SPI_SEQ_TIMEOUT_EN
  logic             timeout;
`endif

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [PW-1:0] tx_rd, tx_wr, rx_rd, rx_wr, rx_rd_nxt;
  logic [CW-1:0] tx_cnt, rx_cnt, tx_cnt_nxt, rx_cnt_nxt;
  logic [7:0]    rx_head, head_nxt;
  logic          tx_full_q, rx_empty_q;
  logic [EW-1:0] err_q, err_nxt;
  logic          flag_d, flag_rise;
  logic          tx_push, tx_ovf, rx_pop, rx_acc, rx_ovf;

  assign flag_rise = SPI_flag & ~flag_d;

  // FIFO bookkeeping; a push into a full FIFO survives only if a pop frees a slot.
  assign tx_push    = host.tx_wr_en && ((tx_cnt != CW'(DEPTH)) || launch);
  assign tx_ovf     = host.tx_wr_en && !tx_push;
  assign tx_cnt_nxt = tx_cnt + CW'(tx_push) - CW'(launch);
  assign rx_pop     = host.rx_rd_en && (rx_cnt != '0);
  assign rx_acc     = rx_push && ((rx_cnt != CW'(DEPTH)) || rx_pop);
  assign rx_ovf     = rx_push && !rx_acc;
  assign rx_cnt_nxt = rx_cnt + CW'(rx_acc) - CW'(rx_pop);
  assign rx_rd_nxt  = rx_rd + PW'(rx_pop);

  // Next FWFT head: the byte being captured if it lands at the new read slot.
  always_comb begin
    head_nxt = rx_head;
    if (rx_cnt_nxt != '0) begin
      if (rx_acc && (rx_rd_nxt == rx_wr)) head_nxt = SPI_data_rec;
      else                                head_nxt = rx_mem[rx_rd_nxt];
    end
  end

  always_comb begin
`ifdef SPI_SEQ_TIMEOUT_EN
    err_nxt = (err_clear ? '0 : err_q) | {timeout, rx_ovf, tx_ovf};
`else
    err_nxt = (err_clear ? '0 : err_q) | {rx_ovf, tx_ovf};
`endif
  end

  always_ff @(posedge clk) begin
    if (!SPI_reset) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    start_nxt = 1'b0;
    launch    = 1'b0;
    rx_push   = 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
    timeout   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (seq_enable && (tx_cnt != '0)) begin
          launch    = 1'b1;
          start_nxt = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (cnt == CNT_W'(START_CYCLES - 1)) begin
          state_nxt = WAIT;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
          start_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (flag_rise) begin
          rx_push   = 1'b1;
          state_nxt = GAP;
        end
`ifdef SPI_SEQ_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout   = 1'b1;
          state_nxt = GAP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
`endif
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) state_nxt = IDLE;
        else                               cnt_nxt   = cnt + CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!SPI_reset) begin
      cnt            <= '0;
      tx_rd          <= '0;
      tx_wr          <= '0;
      rx_rd          <= '0;
      rx_wr          <= '0;
      tx_cnt         <= '0;
      rx_cnt         <= '0;
      tx_full_q      <= 1'b0;
      rx_empty_q     <= 1'b1;
      rx_head        <= '0;
      err_q          <= '0;
      flag_d         <= 1'b1;
      busy           <= 1'b0;
      SPI_start      <= 1'b0;
      SPI_data_trans <= '0;
      SPI_MSB        <= 1'b1;
      SPI_div        <= 2'b01;
    end else begin
      cnt        <= cnt_nxt;
      tx_rd      <= tx_rd + PW'(launch);
      tx_wr      <= tx_wr + PW'(tx_push);
      rx_rd      <= rx_rd_nxt;
      rx_wr      <= rx_wr + PW'(rx_acc);
      tx_cnt     <= tx_cnt_nxt;
      rx_cnt     <= rx_cnt_nxt;
      tx_full_q  <= (tx_cnt_nxt == CW'(DEPTH));
      rx_empty_q <= (rx_cnt_nxt == '0);
      rx_head    <= head_nxt;
      err_q      <= err_nxt;
      flag_d     <= SPI_flag;
      busy       <= (state_nxt != IDLE) || (tx_cnt_nxt != '0);
      SPI_start  <= start_nxt;
      if (launch) begin
        SPI_data_trans <= tx_mem[tx_rd];
        SPI_MSB        <= cfg_msb;
        SPI_div        <= cfg_div;
      end
    end
  end

  // Storage arrays carry no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= host.tx_wr_data;
    if (rx_acc)  rx_mem[rx_wr] <= SPI_data_rec;
  end

  assign host.tx_count   = tx_cnt;
  assign host.rx_count   = rx_cnt;
  assign host.tx_full    = tx_full_q;
  assign host.rx_empty   = rx_empty_q;
  assign host.rx_rd_data = rx_head;
  assign err_sticky      = err_q;
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Self-checking bench for spi_xfer_sequencer: the SPI_master side is emulated
// here, and queues model the host-visible FIFO contents and error bits.
module tb_spi_xfer_sequencer;
  localparam int unsigned DEPTH          = 8;
  localparam int unsigned START_CYCLES   = 2;
  localparam int unsigned GAP_CYCLES     = 1;
  localparam int unsigned TIMEOUT_CYCLES = 16;
`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int unsigned EW = 3;
`else
  localparam int unsigned EW = 2;
`endif

  logic          clk = 1'b0;
  logic          SPI_reset, seq_enable, cfg_msb, err_clear, busy;
  logic [1:0]    cfg_div;
  logic [EW-1:0] err_sticky;
  logic [7:0]    SPI_data_trans, SPI_data_rec;
  logic          SPI_MSB, SPI_start, SPI_flag;
  logic [1:0]    SPI_div;

  int            n_cmp, n_bad, lat;
  logic [7:0]    tx_q[$];
  logic [7:0]    rx_q[$];
  logic [7:0]    rx_last;

  always #5 clk = ~clk;

  spi_xfer_sequencer_if #(.DEPTH(DEPTH)) host ();

  spi_xfer_sequencer #(
    .DEPTH(DEPTH), .START_CYCLES(START_CYCLES), .GAP_CYCLES(GAP_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .SPI_reset(SPI_reset), .seq_enable(seq_enable), .cfg_msb(cfg_msb),
    .cfg_div(cfg_div), .host(host), .busy(busy), .err_sticky(err_sticky),
    .err_clear(err_clear), .SPI_data_trans(SPI_data_trans), .SPI_MSB(SPI_MSB),
    .SPI_div(SPI_div), .SPI_start(SPI_start), .SPI_flag(SPI_flag),
    .SPI_data_rec(SPI_data_rec)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] d);
    host.tx_wr_en   = 1'b1;
    host.tx_wr_data = d;
    tick();
    host.tx_wr_en   = 1'b0;
    if (tx_q.size() < DEPTH) tx_q.push_back(d);
  endtask

  task automatic pop_rx(input string tag);
    host.rx_rd_en = 1'b1;
    tick();
    host.rx_rd_en = 1'b0;
    if (rx_q.size() > 0) rx_last = rx_q.pop_front();
    chk({tag, "_count"}, 32'(host.rx_count), 32'(rx_q.size()));
    chk({tag, "_empty"}, 32'(host.rx_empty), 32'(rx_q.size() == 0));
    chk({tag, "_data"}, 32'(host.rx_rd_data), 32'((rx_q.size() > 0) ? rx_q[0] : rx_last));
  endtask

  // Emulated SPI_master: wait for a launch, check it, answer after dly clocks.
  task automatic serve(input int dly, input int hold, input logic emsb, input logic [1:0] ediv,
                       input logic early, input logic [7:0] rdata, input string tag,
                       output int low_cycles);
    int n;
    logic [7:0] eb;
    n = 0;
    while (SPI_start !== 1'b1 && n < 64) begin tick(); n++; end
    low_cycles = n;
    chk({tag, "_start_seen"}, 32'(SPI_start), 32'd1);
    if (SPI_start !== 1'b1) return;
    eb = (tx_q.size() > 0) ? tx_q.pop_front() : 8'h00;
    chk({tag, "_trans"}, 32'(SPI_data_trans), 32'(eb));
    chk({tag, "_msb"}, 32'(SPI_MSB), 32'(emsb));
    chk({tag, "_div"}, 32'(SPI_div), 32'(ediv));
    cfg_msb = ~emsb;
    cfg_div = ~ediv;
    n = 0;
    while (SPI_start === 1'b1 && n < 64) begin
      SPI_flag = early && (n == 0);
      tick();
      n++;
    end
    SPI_flag = 1'b0;
    chk({tag, "_start_len"}, 32'(n), 32'(START_CYCLES));
    chk({tag, "_cfg_held"}, 32'({SPI_MSB, SPI_div}), 32'({emsb, ediv}));
    repeat (dly) tick();
    SPI_data_rec = rdata;
    SPI_flag     = 1'b1;
    tick();
    cfg_msb = emsb;
    cfg_div = ediv;
    if (rx_q.size() < DEPTH) rx_q.push_back(rdata);
    chk({tag, "_rx_count"}, 32'(host.rx_count), 32'(rx_q.size()));
    chk({tag, "_rx_head"}, 32'(host.rx_rd_data), 32'(rx_q[0]));
    repeat (hold - 1) tick();
    SPI_flag = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    n_cmp = 0; n_bad = 0; rx_last = 8'h00;
    SPI_reset = 1'b0; seq_enable = 1'b0; cfg_msb = 1'b1; cfg_div = 2'b01;
    err_clear = 1'b0; SPI_flag = 1'b0; SPI_data_rec = 8'h00;
    host.tx_wr_en = 1'b0; host.tx_wr_data = 8'h00; host.rx_rd_en = 1'b0;
    tick(); tick();
    chk("rst_tx_count", 32'(host.tx_count), 32'd0);
    chk("rst_rx_count", 32'(host.rx_count), 32'd0);
    chk("rst_rx_empty", 32'(host.rx_empty), 32'd1);
    chk("rst_tx_full", 32'(host.tx_full), 32'd0);
    chk("rst_start", 32'(SPI_start), 32'd0);
    chk("rst_trans", 32'(SPI_data_trans), 32'd0);
    chk("rst_msb", 32'(SPI_MSB), 32'd1);
    chk("rst_div", 32'(SPI_div), 32'd1);
    chk("rst_err", 32'(err_sticky), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_data", 32'(host.rx_rd_data), 32'd0);
    SPI_reset = 1'b1;
    tick();

    // Single byte with known reply
    seq_enable = 1'b1; cfg_msb = 1'b1; cfg_div = 2'b01;
    push_tx(8'h0F);
    serve(20, 1, 1'b1, 2'b01, 1'b0, 8'hA5, "single", lat);
    chk("single_latency", 32'(lat), 32'd1);
    chk("single_rx_data", 32'(host.rx_rd_data), 32'hA5);
    chk("single_rx_cnt", 32'(host.rx_count), 32'd1);
    pop_rx("single_pop");
    pop_rx("empty_pop");
    repeat (4) tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Burst of three, queued before enabling
    seq_enable = 1'b0; cfg_msb = 1'b0; cfg_div = 2'b10;
    push_tx(8'hF0); push_tx(8'h11); push_tx(8'h22);
    seq_enable = 1'b1;
    serve(3, 1, 1'b0, 2'b10, 1'b0, 8'(($urandom)), "burst0", lat);
    for (int i = 1; i < 3; i++) begin
      serve(0, 1, 1'b0, 2'b10, (i == 1), 8'(($urandom)), "burstn", lat);
      chk("burst_gap", 32'(lat), 32'(GAP_CYCLES + 1));
    end
    for (int i = 0; i < 3; i++) pop_rx("burst_pop");

    // Randomized transfers with mid-transfer cfg changes
    for (int k = 0; k < 6; k++) begin
      cfg_msb = 1'(($urandom));
      cfg_div = 2'(($urandom));
      push_tx(8'(($urandom)));
      serve(int'($urandom_range(0, 6)), int'($urandom_range(1, 3)), cfg_msb, cfg_div,
            1'(($urandom)), 8'(($urandom)), "rand", lat);
      chk("rand_latency", 32'(lat), 32'd1);
      if (($urandom % 2) == 0) pop_rx("rand_pop");
    end
    while (rx_q.size() > 0) pop_rx("rand_drain");

    // seq_enable dropped mid-transfer: current byte finishes, no new launch
    seq_enable = 1'b0; cfg_msb = 1'b1; cfg_div = 2'b11;
    push_tx(8'h3C); push_tx(8'hC3);
    seq_enable = 1'b1;
    tick();
    seq_enable = 1'b0;
    serve(2, 1, 1'b1, 2'b11, 1'b0, 8'h5A, "dis0", lat);
    repeat (6) tick();
    chk("dis_no_start", 32'(SPI_start), 32'd0);
    chk("dis_tx_count", 32'(host.tx_count), 32'd1);
    chk("dis_busy", 32'(busy), 32'd1);
    seq_enable = 1'b1;
    serve(1, 2, 1'b1, 2'b11, 1'b0, 8'h96, "dis1", lat);
    pop_rx("dis_pop"); pop_rx("dis_pop");

    // TX overflow and err_clear priority
    seq_enable = 1'b0;
    for (int i = 0; i < 9; i++) push_tx(8'(($urandom)));
    chk("txo_full", 32'(host.tx_full), 32'd1);
    chk("txo_count", 32'(host.tx_count), 32'd8);
    chk("txo_err", 32'(err_sticky), 32'd1);
    chk("txo_busy", 32'(busy), 32'd1);
    err_clear = 1'b1;
    push_tx(8'(($urandom)));
    chk("txo_err_wins", 32'(err_sticky), 32'd1);
    tick();
    err_clear = 1'b0;
    chk("txo_err_clr", 32'(err_sticky), 32'd0);

    // RX overflow: nine transfers without popping
    cfg_msb = 1'b1; cfg_div = 2'b00; seq_enable = 1'b1;
    for (int i = 0; i < 8; i++)
      serve(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), 1'b1, 2'b00,
            1'(($urandom)), 8'(($urandom)), "rxo", lat);
    chk("rxo_pre_err", 32'(err_sticky), 32'd0);
    push_tx(8'(($urandom)));
    serve(1, 1, 1'b1, 2'b00, 1'b0, 8'(($urandom)), "rxo9", lat);
    chk("rxo_count", 32'(host.rx_count), 32'd8);
    chk("rxo_err", 32'(err_sticky), 32'd2);
    for (int i = 0; i < 9; i++) pop_rx("rxo_pop");
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    chk("rxo_err_clr", 32'(err_sticky), 32'd0);

    // Reset during WAIT aborts the transfer
    push_tx(8'h77); push_tx(8'h88);
    lat = 0;
    while (SPI_start !== 1'b1 && lat < 64) begin tick(); lat++; end
    while (SPI_start === 1'b1 && lat < 128) begin tick(); lat++; end
    chk("rstm_in_wait", 32'(busy), 32'd1);
    SPI_reset = 1'b0;
    tick();
    SPI_reset = 1'b1;
    tx_q.delete();
    rx_last = 8'h00;
    chk("rstm_start", 32'(SPI_start), 32'd0);
    chk("rstm_tx_count", 32'(host.tx_count), 32'd0);
    chk("rstm_rx_count", 32'(host.rx_count), 32'd0);
    chk("rstm_busy", 32'(busy), 32'd0);
    SPI_data_rec = 8'h55; SPI_flag = 1'b1;
    tick();
    SPI_flag = 1'b0;
    tick(); tick();
    chk("rstm_flag_ignored", 32'(host.rx_count), 32'd0);
    chk("rstm_rx_empty", 32'(host.rx_empty), 32'd1);

`ifdef SPI_SEQ_TIMEOUT_EN
    // Watchdog: no flag -> GAP without RX push, next byte still launches
    cfg_msb = 1'b1; cfg_div = 2'b01;
    push_tx(8'hE1); push_tx(8'hE2);
    lat = 0;
    while (SPI_start !== 1'b1 && lat < 64) begin tick(); lat++; end
    while (SPI_start === 1'b1 && lat < 128) begin tick(); lat++; end
    void'(tx_q.pop_front());
    lat = 0;
    while (err_sticky[2] !== 1'b1 && lat < 100) begin tick(); lat++; end
    chk("tmo_err", 32'(err_sticky), 32'd4);
    chk("tmo_wait_len", 32'(lat), 32'(TIMEOUT_CYCLES));
    chk("tmo_rx_count", 32'(host.rx_count), 32'd0);
    serve(0, 1, 1'b1, 2'b01, 1'b0, 8'h42, "tmo_next", lat);
    pop_rx("tmo_pop");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
